// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART byte receiver.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } rx_state_e;
`else
  localparam int FRAME_BITS = 10;  // start + 8 data + stop
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } rx_state_e;
`endif

  // Bit-period counter width; the counter never holds more than clks-1.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line with falling-edge detect.
// Flops reset to 1 (idle line). vld_o rises once both stages hold real samples,
// so the reset value is never mistaken for an observed idle-high line.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic fall_o,
  output logic vld_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [1:0] vld_pipe_q;

  // Synchronizer chain, edge-detect history and fill tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      vld_pipe_q <= 2'b00;
    end else begin
      sync_q     <= {sync_q[0], rxd_i};
      prev_q     <= sync_q[1];
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
    end
  end

  assign rxd_s_o = sync_q[1];
  assign fall_o  = prev_q & ~sync_q[1];
  assign vld_o   = vld_pipe_q[1];

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1 by default, 8E1/8O1 when UART_RX_PARITY_EN is defined.
// Start bit is confirmed at mid-bit, then every bit is sampled one period later.
// After a framing error (or reset) a new start needs the line seen high first.
module uart_byte_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       err,
  output logic       busy
);

  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535 || (PARITY_ODD != 0 && PARITY_ODD != 1))
  begin : g_bad_cfg
    $error("uart_byte_rx: illegal CLKS_PER_BIT or PARITY_ODD");
  end

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

  logic rxd_s, fall, sync_vld;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 armed_q, armed_d;
  logic                 tick, start, bad_par;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rxd_i   (rxd),
    .rxd_s_o (rxd_s),
    .fall_o  (fall),
    .vld_o   (sync_vld)
  );

  assign tick  = (cnt_q == '0);
  assign start = fall & armed_q;

`ifdef UART_RX_PARITY_EN
  assign bad_par = ((^shift_q) ^ par_q) != PARITY_ODD[0];
`else
  assign bad_par = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: each non-idle state advances on a counter tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_START;
      S_START:  if (tick) state_d = rxd_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (tick && idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (tick) state_d = S_STOP;
`else
      S_DATA:   if (tick && idx_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:   if (tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: bit timing, shifting, frame result.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = err_q;
    armed_d = armed_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE && !tick) cnt_d = cnt_q - CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (rxd_s && sync_vld) armed_d = 1'b1;
        if (start) begin
          cnt_d = HALF_LD;
          err_d = 1'b0;
        end
      end
      S_START: if (tick && !rxd_s) cnt_d = FULL_LD;
      S_DATA: if (tick) begin
        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
        idx_d   = idx_q + 3'd1;
        cnt_d   = FULL_LD;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) begin
        par_d = rxd_s;
        cnt_d = FULL_LD;
      end
`endif
      S_STOP: if (tick) begin
        ready_d = 1'b1;
        data_d  = shift_q;
        err_d   = ~rxd_s | bad_par;
        if (!rxd_s) armed_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    busy     = (state_q != S_IDLE);
    data_out = data_q;
    ready    = ready_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at CLKS_PER_BIT=16.
module tb_uart_byte_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  // rxd falling edge to ready, plus 2 cycles from the bench pin to the synchronizer output
  localparam int LAT = CPB / 2 + (NBITS - 1) * CPB + 1 + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] data_out;
  logic       ready, err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int c; logic [7:0] d; logic e; } rdy_t;
  rdy_t rq[$];

  uart_byte_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .data_out (data_out),
    .ready    (ready),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every ready cycle; a wide pulse shows up as extra entries.
  always @(negedge clk) if (ready === 1'b1) rq.push_back('{cyc, data_out, err});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge that ends the stop bit with rxd
  // still at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            output int t0);
    t0 = cyc;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      rxd = par;
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic exp_err(input logic [7:0] b, input logic par, input logic stop);
    return !stop || (PAR_EN && ((^b) ^ par));
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] b, input logic e, input int t0);
    rdy_t r;
    chk({tag, "_nrdy"}, rq.size(), 1);
    if (rq.size() > 0) begin
      r = rq.pop_front();
      chk({tag, "_data"}, r.d, b);
      chk({tag, "_err"}, r.e, e);
      chk({tag, "_lat"}, r.c - t0, LAT);
    end
    rq.delete();
  endtask

  initial begin
    int t0, gap, t0b;
    logic [7:0] b;
    logic par, stop, last_err;

    rxd = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    idle(6);

    // Good frame 0xA5
    send_frame(8'hA5, ^8'hA5, 1'b1, t0);
    idle(4);
    check_frame("a5", 8'hA5, 1'b0, t0);

    // Framing error on 0x3C, then break held low
    send_frame(8'h3C, ^8'h3C, 1'b0, t0);
    check_frame("brk", 8'h3C, 1'b1, t0);
    repeat (40) @(negedge clk);
    chk("brk_busy", busy, 1'b0);
    chk("brk_noready", rq.size(), 0);
    chk("brk_err_hold", err, 1'b1);
    chk("brk_data_hold", data_out, 8'h3C);
    idle(4);
    send_frame(8'h5A, ^8'h5A, 1'b1, t0);
    idle(2);
    check_frame("after_brk", 8'h5A, 1'b0, t0);

    // 5-cycle low glitch on idle line
    idle(6);
    t0 = cyc;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    chk("gl_busy_hi", busy, 1'b1);
    rxd = 1'b1;
    repeat (7) @(negedge clk);  // glitch edge + 12: synchronizer 2 + START 9 + margin
    chk("gl_busy_lo", busy, 1'b0);
    chk("gl_noready", rq.size(), 0);
    chk("gl_err", err, 1'b0);
    chk("gl_data", data_out, 8'h5A);
    idle(10);

    // Back-to-back 0x00 then 0xFF with no idle gap
    send_frame(8'h00, 1'b0, 1'b1, t0);
    send_frame(8'hFF, 1'b0, 1'b1, t0b);
    idle(4);
    chk("b2b_nrdy", rq.size(), 2);
    if (rq.size() == 2) begin
      rdy_t r0, r1;
      r0 = rq.pop_front();
      r1 = rq.pop_front();
      chk("b2b0_data", r0.d, 8'h00);
      chk("b2b0_err", r0.e, 1'b0);
      chk("b2b0_lat", r0.c - t0, LAT);
      chk("b2b1_data", r1.d, 8'hFF);
      chk("b2b1_err", r1.e, 1'b0);
      chk("b2b1_lat", r1.c - t0b, LAT);
    end
    rq.delete();

    // Reset during data bit 4 of 0x55; line held low across release
    b = 8'h55;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = b[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_data", data_out, 8'h00);
    chk("mrst_ready", ready, 1'b0);
    chk("mrst_err", err, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("mrst_low_busy", busy, 1'b0);
    chk("mrst_noready", rq.size(), 0);
    idle(5);
    send_frame(8'h12, ^8'h12, 1'b1, t0);
    idle(3);
    check_frame("post_rst", 8'h12, 1'b0, t0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, t0);
    idle(3);
    check_frame("par_ok", 8'h07, 1'b0, t0);
    send_frame(8'h07, 1'b0, 1'b1, t0);
    idle(3);
    check_frame("par_bad", 8'h07, 1'b1, t0);
`endif

    // Random frames: random data, occasional bad stop / bad parity, random gaps
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^b) ^ ($urandom_range(0, 3) == 0);
      gap  = $urandom_range(stop ? 0 : 2, 12);
      send_frame(b, par, stop, t0);
      last_err = exp_err(b, par, stop);
      check_frame($sformatf("rnd%0d", n), b, last_err, t0);
      if (gap > 0) idle(gap);
    end
    idle(4);
    chk("end_noready", rq.size(), 0);
    chk("end_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
